tensor_operand_collector: RTL and testbench

- Upstream feeder for the tensor thread-group stage.
- Accepts one MMA issue request (destination rd, writeback mode, formats), then gathers operands from the register-read path as row-wide beats: one A row, THREAD_GROUP_SIZE B rows, and optionally one C row.
- Presents the complete operand set to the thread group with a valid/ready handshake.
- Holds a single operand set; may accept the next request in the same cycle as the issue handshake.

---
 rtl/tensor_operand_collector.sv | 179 +++++++++++++++++
 tb/tb_tensor_operand_collector.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tensor_operand_collector.sv
// Operand collector ahead of the tensor thread-group stage.
// Accepts one MMA request, gathers one A row, THREAD_GROUP_SIZE B rows and an
// optional C row as row-wide beats, then offers the full operand set to the
// thread group. A new request can be taken in the same cycle the set issues.
module tensor_operand_collector #(
    parameter int XLEN              = 32,
    parameter int THREAD_GROUP_SIZE = 4,
    parameter int RD_BITS           = 5
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            req_valid,
    output logic                                            req_ready,
    input  logic [RD_BITS-1:0]                              req_rd,
    input  logic                                            req_wb,
    input  logic                                            req_fmt_in,
    input  logic                                            req_fmt_out,
    input  logic                                            beat_valid,
    output logic                                            beat_ready,
    input  logic [THREAD_GROUP_SIZE*XLEN-1:0]               beat_data,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [RD_BITS-1:0]                              out_rd,
    output logic                                            out_wb,
    output logic                                            out_fmt_in,
    output logic                                            out_fmt_out,
    output logic [THREAD_GROUP_SIZE*XLEN-1:0]               out_vec_a,
    output logic [THREAD_GROUP_SIZE*THREAD_GROUP_SIZE*XLEN-1:0] out_vec_b,
    output logic [THREAD_GROUP_SIZE*XLEN-1:0]               out_vec_c,
    output logic                                            busy
);

    localparam int ROW_W = THREAD_GROUP_SIZE * XLEN;
    localparam int CNT_W = (THREAD_GROUP_SIZE > 1) ? $clog2(THREAD_GROUP_SIZE) : 1;
    localparam logic [CNT_W-1:0] B_LAST = CNT_W'(THREAD_GROUP_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        LOAD_C,
        ISSUE
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;

    logic [CNT_W-1:0]       b_cnt_reg;
    logic [RD_BITS-1:0]     rd_reg;
    logic                   wb_reg;
    logic                   fmt_in_reg;
    logic                   fmt_out_reg;
    logic [ROW_W-1:0]       a_reg;
    logic [ROW_W-1:0]       c_reg;
    logic [ROW_W-1:0]       b_reg [THREAD_GROUP_SIZE];

    logic                   req_take;
    logic                   beat_take;
    logic                   b_is_last;

    // Handshake strobes; readies depend only on state and out_ready.
    assign req_take  = req_valid  && req_ready;
    assign beat_take = beat_valid && beat_ready;
    assign b_is_last = (b_cnt_reg == B_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        beat_ready = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = LOAD_A;
                end
            end
            LOAD_A: begin
                beat_ready = 1'b1;
                if (beat_valid) begin
                    state_next = LOAD_B;
                end
            end
            LOAD_B: begin
                beat_ready = 1'b1;
                if (beat_valid && b_is_last) begin
                    state_next = wb_reg ? LOAD_C : ISSUE;
                end
            end
            LOAD_C: begin
                beat_ready = 1'b1;
                if (beat_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                out_valid = 1'b1;
                // The slot frees up exactly when the current set is taken.
                req_ready = out_ready;
                if (out_ready) begin
                    state_next = req_valid ? LOAD_A : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request metadata and operand rows; B row index advances only on beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_cnt_reg   <= '0;
            rd_reg      <= '0;
            wb_reg      <= 1'b0;
            fmt_in_reg  <= 1'b0;
            fmt_out_reg <= 1'b0;
            a_reg       <= '0;
            c_reg       <= '0;
            for (int r = 0; r < THREAD_GROUP_SIZE; r++) begin
                b_reg[r] <= '0;
            end
        end else begin
            if (req_take) begin
                rd_reg      <= req_rd;
                wb_reg      <= req_wb;
                fmt_in_reg  <= req_fmt_in;
                fmt_out_reg <= req_fmt_out;
                // A wb=0 op must present C as zero, so drop any stale row now.
                c_reg       <= '0;
            end
            if (beat_take) begin
                case (state_reg)
                    LOAD_A: begin
                        a_reg     <= beat_data;
                        b_cnt_reg <= '0;
                    end
                    LOAD_B: begin
                        b_reg[b_cnt_reg] <= beat_data;
                        if (!b_is_last) begin
                            b_cnt_reg <= b_cnt_reg + CNT_W'(1);
                        end
                    end
                    LOAD_C: begin
                        c_reg <= beat_data;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign out_rd      = rd_reg;
    assign out_wb      = wb_reg;
    assign out_fmt_in  = fmt_in_reg;
    assign out_fmt_out = fmt_out_reg;
    assign out_vec_a   = a_reg;
    assign out_vec_c   = c_reg;
    assign busy        = (state_reg != IDLE);

    // Flatten B rows, row 0 in the LSBs.
    generate
        for (genvar gi = 0; gi < THREAD_GROUP_SIZE; gi++) begin : g_b_rows
            assign out_vec_b[gi*ROW_W +: ROW_W] = b_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_tensor_operand_collector.sv
// Scoreboard bench for tensor_operand_collector: stimulus pushes the expected
// operand set per request, an output monitor pops and compares on each issue.
module tb_tensor_operand_collector;

    localparam int XLEN  = 32;
    localparam int TGS   = 4;
    localparam int RDB   = 5;
    localparam int ROW_W = TGS * XLEN;
    localparam int B_W   = TGS * ROW_W;

    typedef struct {
        logic [RDB-1:0]   rd;
        logic             wb;
        logic             fi;
        logic             fo;
        logic [ROW_W-1:0] a;
        logic [B_W-1:0]   b;
        logic [ROW_W-1:0] c;
    } op_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [RDB-1:0]   req_rd;
    logic             req_wb;
    logic             req_fmt_in;
    logic             req_fmt_out;
    logic             beat_valid;
    logic             beat_ready;
    logic [ROW_W-1:0] beat_data;
    logic             out_valid;
    logic             out_ready;
    logic [RDB-1:0]   out_rd;
    logic             out_wb;
    logic             out_fmt_in;
    logic             out_fmt_out;
    logic [ROW_W-1:0] out_vec_a;
    logic [B_W-1:0]   out_vec_b;
    logic [ROW_W-1:0] out_vec_c;
    logic             busy;

    int  total = 0;
    int  bad = 0;
    int  beats_seen = 0;
    time req_t = 0;
    time fire_neg_t = 0;
    op_t sb[$];

    tensor_operand_collector #(
        .XLEN(XLEN), .THREAD_GROUP_SIZE(TGS), .RD_BITS(RDB)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
        .req_wb(req_wb), .req_fmt_in(req_fmt_in), .req_fmt_out(req_fmt_out),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_wb(out_wb), .out_fmt_in(out_fmt_in), .out_fmt_out(out_fmt_out),
        .out_vec_a(out_vec_a), .out_vec_b(out_vec_b), .out_vec_c(out_vec_c),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [B_W-1:0] act, input logic [B_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    function automatic logic [ROW_W-1:0] mk_row(input logic [31:0] l0, input logic [31:0] l1,
                                                input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Count accepted beats independently of stimulus.
    always @(negedge clk) begin
        if (!reset && beat_valid && beat_ready) beats_seen++;
    end

    // Output monitor: every issue handshake pops one expected operand set.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            fire_neg_t = $time;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_issue: got rd=%0d expected no issue", out_rd);
            end else begin
                op_t e;
                e = sb.pop_front();
                $display("issue rd=%0d wb=%0d fmt=%0d/%0d a=%h c=%h", out_rd, out_wb,
                         out_fmt_in, out_fmt_out, out_vec_a, out_vec_c);
                chk("out_rd", out_rd, e.rd);
                chk("out_wb", out_wb, e.wb);
                chk("out_fmt_in", out_fmt_in, e.fi);
                chk("out_fmt_out", out_fmt_out, e.fo);
                chk("out_vec_a", out_vec_a, e.a);
                chk("out_vec_b", out_vec_b, e.b);
                chk("out_vec_c", out_vec_c, e.c);
            end
        end
    end

    // All drive tasks are entered just after a rising edge.
    task automatic preload(input op_t n);
        req_rd      = n.rd;
        req_wb      = n.wb;
        req_fmt_in  = n.fi;
        req_fmt_out = n.fo;
        req_valid   = 1'b1;
    endtask

    task automatic send_req(input op_t op);
        int n;
        preload(op);
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 50) begin
                timeout("req_handshake");
                break;
            end
        end
        @(posedge clk);
        req_t = $time;
        #1 req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [ROW_W-1:0] d);
        int n;
        beat_valid = 1'b1;
        beat_data  = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (beat_ready) break;
            n++;
            if (n > 50) begin
                timeout("beat_handshake");
                break;
            end
        end
        @(posedge clk);
        #1 beat_valid = 1'b0;
    endtask

    task automatic push_exp(input op_t op);
        op_t e;
        e = op;
        if (!op.wb) e.c = '0;
        sb.push_back(e);
    endtask

    // Drive A, B rows (optionally gapped) and C; optionally raise the next
    // request alongside the final beat.
    task automatic send_operands(input op_t op, input int gap, input bit chain, input op_t nxt);
        send_beat(op.a);
        for (int r = 0; r < TGS; r++) begin
            if (chain && !op.wb && r == TGS - 1) preload(nxt);
            send_beat(op.b[r*ROW_W +: ROW_W]);
            for (int g = 0; g < gap; g++) begin
                beat_data = '1;
                @(posedge clk);
                #1;
            end
        end
        if (op.wb) begin
            if (chain) preload(nxt);
            send_beat(op.c);
        end
    endtask

    task automatic run_op(input op_t op, input int gap);
        send_req(op);
        push_exp(op);
        send_operands(op, gap, 1'b0, op);
    endtask

    // Returns on the falling edge where out_valid is first seen, with latency in cycles.
    task automatic wait_valid(output int lat);
        int n;
        n = 0;
        lat = -1;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                lat = int'(($time - 5 - req_t) / 10);
                break;
            end
            n++;
            if (n > 60) begin
                timeout("out_valid");
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        op_t op1, op2, op3, op4a, op4b, op5, op6, op7;
        int  lat;
        int  b0;

        op1.rd = 5;  op1.wb = 1; op1.fi = 0; op1.fo = 1;
        op1.a = mk_row(1, 2, 3, 4);
        op1.b = {mk_row('h40, 'h41, 'h42, 'h43), mk_row('h30, 'h31, 'h32, 'h33),
                 mk_row('h20, 'h21, 'h22, 'h23), mk_row('h10, 'h11, 'h12, 'h13)};
        op1.c = mk_row('h99, 'h99, 'h99, 'h99);

        op2.rd = 9;  op2.wb = 0; op2.fi = 1; op2.fo = 0;
        op2.a = mk_row('ha1, 'ha2, 'ha3, 'ha4);
        op2.b = {mk_row('hb30, 'hb31, 'hb32, 'hb33), mk_row('hb20, 'hb21, 'hb22, 'hb23),
                 mk_row('hb10, 'hb11, 'hb12, 'hb13), mk_row('hb00, 'hb01, 'hb02, 'hb03)};
        op2.c = mk_row('h55, 'h55, 'h55, 'h55);

        op3.rd = 12; op3.wb = 1; op3.fi = 1; op3.fo = 1;
        op3.a = mk_row('hdead0000, 'hdead0001, 'hdead0002, 'hdead0003);
        op3.b = {mk_row(34, 35, 36, 37), mk_row(24, 25, 26, 27),
                 mk_row(14, 15, 16, 17), mk_row(4, 5, 6, 7)};
        op3.c = mk_row('hc0, 'hc1, 'hc2, 'hc3);

        op4a.rd = 3; op4a.wb = 0; op4a.fi = 0; op4a.fo = 0;
        op4a.a = mk_row('h3a, 'h3a, 'h3a, 'h3a);
        op4a.b = {mk_row('h33, 0, 0, 0), mk_row('h32, 0, 0, 0),
                  mk_row('h31, 0, 0, 0), mk_row('h30, 0, 0, 0)};
        op4a.c = '0;

        op4b.rd = 7; op4b.wb = 0; op4b.fi = 1; op4b.fo = 0;
        op4b.a = mk_row('h7a, 'h7a, 'h7a, 'h7a);
        op4b.b = {mk_row(0, 0, 0, 'h73), mk_row(0, 0, 0, 'h72),
                  mk_row(0, 0, 0, 'h71), mk_row(0, 0, 0, 'h70)};
        op4b.c = '0;

        op5.rd = 20; op5.wb = 1; op5.fi = 0; op5.fo = 1;
        op5.a = mk_row('h501, 'h502, 'h503, 'h504);
        op5.b = {mk_row('h5300, 'h5301, 'h5302, 'h5303), mk_row('h5200, 'h5201, 'h5202, 'h5203),
                 mk_row('h5100, 'h5101, 'h5102, 'h5103), mk_row('h5000, 'h5001, 'h5002, 'h5003)};
        op5.c = mk_row('h5c, 'h5d, 'h5e, 'h5f);

        op6.rd = 11; op6.wb = 1; op6.fi = 1; op6.fo = 1;
        op6.a = mk_row('h66, 'h66, 'h66, 'h66);
        op6.b = {mk_row('h63, 0, 0, 0), mk_row('h62, 0, 0, 0),
                 mk_row('h61, 0, 0, 0), mk_row('h60, 0, 0, 0)};
        op6.c = mk_row('h6c, 'h6c, 'h6c, 'h6c);

        op7.rd = 2;  op7.wb = 1; op7.fi = 0; op7.fo = 0;
        op7.a = mk_row('h70a, 'h70b, 'h70c, 'h70d);
        op7.b = {mk_row('h7030, 'h7031, 'h7032, 'h7033), mk_row('h7020, 'h7021, 'h7022, 'h7023),
                 mk_row('h7010, 'h7011, 'h7012, 'h7013), mk_row('h7000, 'h7001, 'h7002, 'h7003)};
        op7.c = mk_row('h7c0, 'h7c1, 'h7c2, 'h7c3);

        reset = 1'b1; req_valid = 1'b0; req_rd = '0; req_wb = 1'b0;
        req_fmt_in = 1'b0; req_fmt_out = 1'b0; beat_valid = 1'b0;
        beat_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_beat_ready", beat_ready, 0);
        chk("rst_vec_a", out_vec_a, 0);
        @(posedge clk); #1;

        // wb=1 op, back-to-back beats: 6-cycle latency.
        run_op(op1, 0);
        wait_valid(lat);
        chk("wb1_latency", lat, 6);
        chk("wb1_vec_a_literal", out_vec_a, 128'h00000004_00000003_00000002_00000001);
        @(posedge clk); #1;

        // wb=0 op: five beats only, C forced to zero, no beats taken in ISSUE.
        b0 = beats_seen;
        run_op(op2, 0);
        beat_valid = 1'b1;
        beat_data  = '1;
        wait_valid(lat);
        chk("wb0_latency", lat, 5);
        chk("wb0_issue_beat_ready", beat_ready, 0);
        repeat (3) @(posedge clk);
        #1 beat_valid = 1'b0;
        chk("wb0_beat_count", beats_seen - b0, 5);

        // Backpressure in ISSUE for 10 cycles with stray beat pulses.
        out_ready = 1'b0;
        run_op(op3, 0);
        wait_valid(lat);
        b0 = beats_seen;
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_out_rd", out_rd, 12);
            chk("bp_vec_c", out_vec_c, op3.c);
            @(posedge clk);
            #1 beat_valid = ~beat_valid;
            beat_data = '1;
            @(negedge clk);
        end
        @(posedge clk);
        #1 beat_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_beats_ignored", beats_seen - b0, 0);
        @(negedge clk);
        chk("bp_fire_valid", out_valid, 1);
        @(negedge clk);
        chk("bp_after_valid", out_valid, 0);
        chk("bp_after_busy", busy, 0);
        @(posedge clk); #1;

        // Back-to-back: next request taken on the issue edge of rd=3.
        send_req(op4a);
        push_exp(op4a);
        send_operands(op4a, 0, 1'b1, op4b);
        send_req(op4b);
        push_exp(op4b);
        chk("b2b_accept_edge", req_t, fire_neg_t + 5);
        @(negedge clk);
        chk("b2b_load_a_busy", busy, 1);
        chk("b2b_load_a_beat_ready", beat_ready, 1);
        chk("b2b_load_a_out_valid", out_valid, 0);
        @(posedge clk); #1;
        send_operands(op4b, 0, 1'b0, op4b);
        wait_valid(lat);
        @(posedge clk); #1;

        // Beat gaps between B rows.
        run_op(op5, 1);
        wait_valid(lat);
        chk("gap_latency", lat, 10);
        @(posedge clk); #1;

        // Reset during LOAD_B after two rows, then a fresh op.
        send_req(op6);
        send_beat(op6.a);
        send_beat(op6.b[0 +: ROW_W]);
        send_beat(op6.b[ROW_W +: ROW_W]);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_vec_a", out_vec_a, 0);
        chk("midrst_vec_b", out_vec_b, 0);
        chk("midrst_out_rd", out_rd, 0);
        @(posedge clk); #1;
        run_op(op7, 0);
        wait_valid(lat);
        chk("fresh_latency", lat, 6);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
